// File: rtl/qam64_pkg.sv
// 64QAM mapper shared definitions: Gray-to-level constants, engine state
// encoding and the phase-counter width helper.
// Pure declarations, no logic.
package qam64_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Odd constellation levels on one axis, 4-bit two's complement.
  localparam logic signed [3:0] LVL_M7 = -4'sd7;
  localparam logic signed [3:0] LVL_M5 = -4'sd5;
  localparam logic signed [3:0] LVL_M3 = -4'sd3;
  localparam logic signed [3:0] LVL_M1 = -4'sd1;
  localparam logic signed [3:0] LVL_P1 = 4'sd1;
  localparam logic signed [3:0] LVL_P3 = 4'sd3;
  localparam logic signed [3:0] LVL_P5 = 4'sd5;
  localparam logic signed [3:0] LVL_P7 = 4'sd7;

  // Phase counter width for an upsample factor l (l >= 2, so never zero).
  function automatic int phase_w_of(input int l);
    return $clog2(l);
  endfunction

endpackage

// File: rtl/qam64_gray_mapper.sv
// Purpose: maps one 3-bit Gray-coded axis to a signed odd level in -7..+7.
// Latency: combinational.  Backpressure: none (pure function).
// Ports: gray (3-bit Gray code in), level (4-bit signed level out).
module qam64_gray_mapper
  import qam64_pkg::*;
(
  input  logic [2:0]        gray,
  output logic signed [3:0] level
);

  always_comb begin
    level = LVL_M7;
    case (gray)
      3'b000: level = LVL_M7;
      3'b001: level = LVL_M5;
      3'b011: level = LVL_M3;
      3'b010: level = LVL_M1;
      3'b110: level = LVL_P1;
      3'b111: level = LVL_P3;
      3'b101: level = LVL_P5;
      3'b100: level = LVL_P7;
      default: level = LVL_M7;
    endcase
  end

endmodule

// File: rtl/qam64_zero_stuff_upsampler.sv
// Purpose: Gray-maps 6-bit 64QAM symbols to I/Q levels and emits an L-times
//   zero-stuffed stream (impulse then L-1 zeros per symbol) to the shaping FIR.
// Latency: symbol accepted at edge k -> impulse valid after edge k+1.
// Backpressure: out_ready low freezes all output regs and phase; one-entry hold
//   register keeps accepting, sym_ready = ~hold_full (registered).
// Ports: clk/rst (async active-high); sym_valid/sym_data/sym_ready symbol input;
//   out_valid/out_ready/out_i/out_q/out_first sample output; busy = engine in RUN;
//   underrun_cnt = saturating count of stream gaps.
module qam64_zero_stuff_upsampler
  import qam64_pkg::*;
#(
  parameter int L     = 4,
  parameter int OUT_W = 12,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sym_valid,
  input  logic [5:0]              sym_data,
  output logic                    sym_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic                    out_first,
  output logic                    busy,
  output logic [CNT_W-1:0]        underrun_cnt
);

  localparam int PHASE_W = phase_w_of(L);

  state_t             state, state_d;
  logic [5:0]         hold;
  logic               hold_full;
  logic [PHASE_W-1:0] phase;
  logic signed [3:0]  lvl_i, lvl_q;
  logic               adv, phase_last;
  logic               load_imp, load_zero, go_idle;

  qam64_gray_mapper u_map_i (.gray(hold[5:3]), .level(lvl_i));
  qam64_gray_mapper u_map_q (.gray(hold[2:0]), .level(lvl_q));

  assign adv        = ~out_valid | out_ready;
  assign phase_last = (phase == PHASE_W'(L - 1));
  assign sym_ready  = ~hold_full;
  assign busy       = (state == RUN);

  // Next state plus one-hot datapath actions for this edge.
  always_comb begin
    state_d   = state;
    load_imp  = 1'b0;
    load_zero = 1'b0;
    go_idle   = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load_imp = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          if (!phase_last) begin
            load_zero = 1'b1;
          end else if (hold_full) begin
            load_imp = 1'b1;
          end else begin
            go_idle = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold         <= '0;
      hold_full    <= 1'b0;
      phase        <= '0;
      out_valid    <= 1'b0;
      out_i        <= '0;
      out_q        <= '0;
      out_first    <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      // Accept only when empty, consume only when full: never the same edge.
      if (sym_valid && !hold_full) begin
        hold      <= sym_data;
        hold_full <= 1'b1;
      end else if (load_imp) begin
        hold_full <= 1'b0;
      end

      if (load_imp) begin
        out_i     <= OUT_W'(lvl_i);
        out_q     <= OUT_W'(lvl_q);
        out_first <= 1'b1;
        out_valid <= 1'b1;
        phase     <= '0;
      end else if (load_zero) begin
        out_i     <= '0;
        out_q     <= '0;
        out_first <= 1'b0;
        out_valid <= 1'b1;
        phase     <= phase + PHASE_W'(1);
      end else if (go_idle) begin
        out_i     <= '0;
        out_q     <= '0;
        out_first <= 1'b0;
        out_valid <= 1'b0;
        if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_qam64_zero_stuff_upsampler.sv
// Bench for qam64_zero_stuff_upsampler: three instances (L=4 default, L=4 with
// a 2-bit counter, L=2); a scoreboard queue per streaming instance holds the
// expected samples pushed when each symbol is accepted.
module tb_qam64_zero_stuff_upsampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv[3];
  logic [5:0]  sd[3];
  logic        sr[3];
  logic        ov[3];
  logic        ordy[3];
  logic [11:0] oi[3];
  logic [11:0] oq[3];
  logic        of[3];
  logic        bz[3];
  logic [15:0] cnt0, cnt2;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  qam64_zero_stuff_upsampler #(.L(4), .OUT_W(12), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sym_valid(sv[0]), .sym_data(sd[0]), .sym_ready(sr[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_i(oi[0]), .out_q(oq[0]),
    .out_first(of[0]), .busy(bz[0]), .underrun_cnt(cnt0));

  qam64_zero_stuff_upsampler #(.L(4), .OUT_W(12), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .sym_valid(sv[1]), .sym_data(sd[1]), .sym_ready(sr[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_i(oi[1]), .out_q(oq[1]),
    .out_first(of[1]), .busy(bz[1]), .underrun_cnt(cnt1));

  qam64_zero_stuff_upsampler #(.L(2), .OUT_W(12), .CNT_W(16)) dut_l2 (
    .clk(clk), .rst(rst), .sym_valid(sv[2]), .sym_data(sd[2]), .sym_ready(sr[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_i(oi[2]), .out_q(oq[2]),
    .out_first(of[2]), .busy(bz[2]), .underrun_cnt(cnt2));

  typedef struct {
    int i;
    int q;
    bit first;
  } smp_t;

  smp_t q0[$];
  smp_t q2[$];
  int   vectors = 0;
  int   miscompares = 0;
  // Gray code index -> level: 000 001 010 011 100 101 110 111
  int   gray_lvl[8] = '{-7, -5, -1, -3, 7, 5, 1, 3};

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q2.delete();
  endtask

  // Present one symbol at a negedge, hold until accepted, then queue its samples.
  task automatic send(input int d, input logic [5:0] data);
    int   b = 0;
    int   ln;
    smp_t s;
    @(negedge clk);
    sv[d] = 1'b1;
    sd[d] = data;
    while (!sr[d] && b < 100) begin
      @(negedge clk);
      b++;
    end
    vectors++;
    if (!sr[d]) begin
      miscompares++;
      $display("FAIL send_timeout dut%0d: sym_ready=%b required 1", d, sr[d]);
      sv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 sv[d] = 1'b0;
    ln = (d == 2) ? 2 : 4;
    for (int k = 0; k < ln; k++) begin
      s.i     = (k == 0) ? gray_lvl[data[5:3]] : 0;
      s.q     = (k == 0) ? gray_lvl[data[2:0]] : 0;
      s.first = (k == 0);
      if (d == 0) q0.push_back(s);
      else if (d == 2) q2.push_back(s);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (ov[0] !== 1'b0 || sr[0] !== 1'b1 || bz[0] !== 1'b0 || of[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: valid=%b ready=%b busy=%b first=%b required 0 1 0 0",
               ov[0], sr[0], bz[0], of[0]);
    end
    vectors++;
    if (oi[0] !== 12'd0 || oq[0] !== 12'd0 || cnt0 !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_regs: i=%0d q=%0d cnt=%0d required 0 0 0", oi[0], oq[0], cnt0);
    end
    // One finished symbol so the counter is non-zero before the async reset.
    send(0, 6'b010_101);
    repeat (8) @(negedge clk);
    vectors++;
    if (cnt0 !== 16'd1) begin
      miscompares++;
      $display("FAIL reset_precount: underrun_cnt=%0d required 1", cnt0);
    end
    q0.delete();
    send(0, 6'b111_001);
    send(0, 6'b001_111);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bz[0] !== 1'b1 || sr[0] !== 1'b0 || ov[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_midrun_pre: busy=%b ready=%b valid=%b required 1 0 1",
               bz[0], sr[0], ov[0]);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (ov[0] !== 1'b0 || sr[0] !== 1'b1 || cnt0 !== 16'd0 || bz[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: valid=%b ready=%b cnt=%0d busy=%b required 0 1 0 0",
               ov[0], sr[0], cnt0, bz[0]);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int   got = 0, gaps = 0, cyc = 0;
    bit   started = 0;
    smp_t e;
    apply_reset();
    send(0, 6'b100_000);
    @(negedge clk);
    vectors++;
    if (ov[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency: out_valid=%b required 0 one cycle after accept", ov[0]);
    end
    while (got < 4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (ov[0] && ordy[0]) begin
        e = q0.pop_front();
        vectors++;
        if ($signed(oi[0]) !== e.i || $signed(oq[0]) !== e.q || of[0] !== e.first) begin
          miscompares++;
          $display("FAIL single_sample%0d: got (%0d,%0d,%b) required (%0d,%0d,%b)",
                   got, $signed(oi[0]), $signed(oq[0]), of[0], e.i, e.q, e.first);
        end
        got++;
        started = 1;
      end else if (started) gaps++;
    end
    vectors++;
    if (got != 4 || gaps != 0) begin
      miscompares++;
      $display("FAIL single_count: samples=%0d gaps=%0d required 4 0", got, gaps);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (ov[0] !== 1'b0 || cnt0 !== 16'd1 || bz[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: valid=%b cnt=%0d busy=%b required 0 1 0", ov[0], cnt0, bz[0]);
    end
  endtask

  task automatic test_back_to_back();
    int   got = 0, gaps = 0, cyc = 0;
    bit   started = 0;
    smp_t e;
    apply_reset();
    fork
      begin
        for (int s = 0; s < 64; s++) send(0, 6'(s));
      end
      begin
        while (got < 256 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (ov[0] && ordy[0]) begin
            vectors++;
            if (q0.size() == 0) begin
              miscompares++;
              $display("FAIL b2b_extra: sample %0d with empty scoreboard", got);
            end else begin
              e = q0.pop_front();
              if ($signed(oi[0]) !== e.i || $signed(oq[0]) !== e.q || of[0] !== e.first) begin
                miscompares++;
                $display("FAIL b2b_sample%0d: got (%0d,%0d,%b) required (%0d,%0d,%b)",
                         got, $signed(oi[0]), $signed(oq[0]), of[0], e.i, e.q, e.first);
              end
            end
            got++;
            started = 1;
            if (got == 256) begin
              vectors++;
              if (cnt0 !== 16'd0) begin
                miscompares++;
                $display("FAIL b2b_underrun: underrun_cnt=%0d required 0", cnt0);
              end
            end
          end else if (started) gaps++;
        end
      end
    join
    vectors++;
    if (got != 256 || gaps != 0) begin
      miscompares++;
      $display("FAIL b2b_count: samples=%0d gaps=%0d required 256 0", got, gaps);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (ov[0] !== 1'b0 || cnt0 !== 16'd1) begin
      miscompares++;
      $display("FAIL b2b_tail: valid=%b cnt=%0d required 0 1", ov[0], cnt0);
    end
  endtask

  task automatic test_backpressure();
    int   got = 0, gaps = 0, cyc = 0;
    smp_t e;
    apply_reset();
    send(0, 6'b110_011);
    @(negedge clk);
    @(negedge clk);
    e = q0.pop_front();
    vectors++;
    if (ov[0] !== 1'b1 || $signed(oi[0]) !== e.i || $signed(oq[0]) !== e.q || of[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_impulse: got (%0d,%0d,%b,v=%b) required (%0d,%0d,1,v=1)",
               $signed(oi[0]), $signed(oq[0]), of[0], ov[0], e.i, e.q);
    end
    @(negedge clk);
    ordy[0] = 1'b0;
    send(0, 6'b011_110);
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (ov[0] !== 1'b1 || of[0] !== 1'b0 || oi[0] !== 12'd0 || oq[0] !== 12'd0 || sr[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_frozen: valid=%b first=%b i=%0d q=%0d ready=%b required 1 0 0 0 0",
                 ov[0], of[0], oi[0], oq[0], sr[0]);
      end
    end
    ordy[0] = 1'b1;
    e = q0.pop_front();
    vectors++;
    if ($signed(oi[0]) !== e.i || of[0] !== e.first) begin
      miscompares++;
      $display("FAIL bp_phase1: got (%0d,%b) required (%0d,%b)", $signed(oi[0]), of[0], e.i, e.first);
    end
    while (got < 6 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (ov[0] && ordy[0]) begin
        e = q0.pop_front();
        vectors++;
        if ($signed(oi[0]) !== e.i || $signed(oq[0]) !== e.q || of[0] !== e.first ||
            (e.first && sr[0] !== 1'b1)) begin
          miscompares++;
          $display("FAIL bp_sample%0d: got (%0d,%0d,%b,rdy=%b) required (%0d,%0d,%b)",
                   got, $signed(oi[0]), $signed(oq[0]), of[0], sr[0], e.i, e.q, e.first);
        end
        got++;
      end else gaps++;
    end
    vectors++;
    if (got != 6 || gaps != 0) begin
      miscompares++;
      $display("FAIL bp_count: samples=%0d gaps=%0d required 6 0", got, gaps);
    end
  endtask

  task automatic test_saturation();
    int ex;
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      send(1, 6'(k * 9));
      repeat (8) @(negedge clk);
      ex = (k > 3) ? 3 : k;
      vectors++;
      if (int'(cnt1) != ex) begin
        miscompares++;
        $display("FAIL sat_cnt%0d: underrun_cnt=%0d required %0d", k, cnt1, ex);
      end
    end
  endtask

  task automatic test_l2_stream();
    int   got = 0, gaps = 0, cyc = 0;
    bit   started = 0;
    smp_t e;
    apply_reset();
    fork
      begin
        for (int s = 0; s < 10; s++) send(2, 6'(s * 7 + 3));
      end
      begin
        while (got < 20 && cyc < 500) begin
          @(negedge clk);
          cyc++;
          if (ov[2] && ordy[2]) begin
            vectors++;
            if (q2.size() == 0) begin
              miscompares++;
              $display("FAIL l2_extra: sample %0d with empty scoreboard", got);
            end else begin
              e = q2.pop_front();
              if ($signed(oi[2]) !== e.i || $signed(oq[2]) !== e.q || of[2] !== e.first) begin
                miscompares++;
                $display("FAIL l2_sample%0d: got (%0d,%0d,%b) required (%0d,%0d,%b)",
                         got, $signed(oi[2]), $signed(oq[2]), of[2], e.i, e.q, e.first);
              end
            end
            got++;
            started = 1;
            if (got == 20) begin
              vectors++;
              if (cnt2 !== 16'd0) begin
                miscompares++;
                $display("FAIL l2_underrun: underrun_cnt=%0d required 0", cnt2);
              end
            end
          end else if (started) gaps++;
        end
      end
    join
    vectors++;
    if (got != 20 || gaps != 0) begin
      miscompares++;
      $display("FAIL l2_count: samples=%0d gaps=%0d required 20 0", got, gaps);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      sv[d]   = 1'b0;
      sd[d]   = 6'd0;
      ordy[d] = 1'b1;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_l2_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
